multi_schmitt_not_gate: RTL and testbench
=========================================

MULTI_SCHMITT_NOT_GATE -- requirements
Module: multi_schmitt_not_gate

Interface
REQ-001 Parameter WIDTH, default 6, sets the number of independent channels (legal 1..32).
REQ-002 Parameter FILTER, default 4, sets the consecutive stable cycles required to accept an input change (legal 1..255).
REQ-003 Parameter INVERT, default 1: 1 = inverting channels, 0 = non-inverting buffer channels.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  filter enable: 1 = hysteresis filter active, 0 = filter bypassed.
REQ-007 A  input  WIDTH  asynchronous channel inputs, bit i = channel i.
REQ-008 Y  output  WIDTH  registered filtered outputs, bit i = channel i.
REQ-009 changed  output  WIDTH  one-cycle pulse per channel when that channel's filtered level toggles.

Function
REQ-010 Each channel SHALL pass A[i] through a 2-flop synchroniser (sync1, sync2) before any other logic.
REQ-011 Each channel SHALL hold a filtered level s[i] and a counter c[i] of width ceil(log2(FILTER+1)).
REQ-012 en=1, sync2 == s: c SHALL clear to 0; s holds.
REQ-013 en=1, sync2 != s, c < FILTER-1: c SHALL increment by 1; s holds.
REQ-014 en=1, sync2 != s, c == FILTER-1: s SHALL take sync2, c SHALL clear, changed[i] SHALL be 1 for that cycle.
REQ-015 The counter SHALL never exceed FILTER-1 and SHALL never wrap.
REQ-016 en=0: s SHALL take sync2 every cycle and c SHALL clear to 0; changed[i] SHALL pulse on any s change.
REQ-017 Y[i] SHALL equal ~s[i] when INVERT=1 and s[i] when INVERT=0, driven from registers with no combinational path from A.
REQ-018 changed[i] SHALL be registered and SHALL be 1 for exactly one cycle per toggle of s[i].
REQ-019 Latency, en=1: A change stable before edge 1 SHALL appear on Y after edge 2+FILTER (FILTER=4: edge 6).
REQ-020 Latency, en=0: A change stable before edge 1 SHALL appear on Y after edge 3.
REQ-021 A pulse on A shorter than FILTER sampled cycles SHALL produce no change on Y or changed (en=1).
REQ-022 en changing mid-count SHALL take effect at the next edge: 1->0 loads sync2 and clears c; 0->1 starts counting from c=0.
REQ-023 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-012..REQ-016.

Reset
REQ-024 rst=1 at an edge SHALL clear sync1, sync2, s and c on all channels and SHALL clear changed to 0.
REQ-025 After reset Y SHALL be all ones when INVERT=1 and all zeros when INVERT=0.
REQ-026 rst SHALL take priority over en and A; a reset mid-count SHALL discard the partial count.
REQ-027 After rst release, input acceptance SHALL restart from the synchroniser (full REQ-019/REQ-020 latency).

Verification (WIDTH=6, FILTER=4, INVERT=1 unless stated)
REQ-028 rst=1 one edge, A=6'h00 -> Y=6'h3F, changed=6'h00.
REQ-029 en=1, A steps 6'h00->6'h01 and holds -> Y=6'h3E after edge 6, changed=6'h01 on that cycle only, 6'h00 thereafter.
REQ-030 en=1, A[1]=1 for 3 cycles then 0 -> Y stays 6'h3F, changed stays 6'h00.
REQ-031 en=0, A steps to 6'h2A -> Y=6'h15 after edge 3, changed=6'h2A for one cycle.
REQ-032 en=1, A=6'h3F held 4 cycles, then rst=1 one edge, A still 6'h3F -> Y=6'h3F during and after reset until edge 6 after release, then Y=6'h00.
REQ-033 INVERT=0, en=1, A=6'h3F held -> Y=6'h00 after reset, Y=6'h3F after edge 6, changed=6'h3F for one cycle.

Source files
------------

// File: rtl/multi_schmitt_not_gate.sv
// rtl/multi_schmitt_not_gate.sv - multi-channel synchronised hysteresis filter with optional inversion
module multi_schmitt_not_gate #(
  parameter int WIDTH  = 6,
  parameter int FILTER = 4,
  parameter int INVERT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] changed
);

  // Counter only has to reach FILTER-1, so it never needs to wrap.
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_next;
  logic [CW-1:0]    c      [WIDTH];
  logic [CW-1:0]    c_next [WIDTH];

  // Per-channel filter decision: accept a new level only after a full stable run.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      s_next[i] = s[i];
      c_next[i] = '0;
      if (!en) begin
        s_next[i] = sync2[i];
      end else if (sync2[i] != s[i]) begin
        if (c[i] == C_LAST) begin
          s_next[i] = sync2[i];
        end else begin
          c_next[i] = c[i] + C_ONE;
        end
      end
    end
  end

  // Synchroniser, filtered level, run counters and the toggle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      s       <= '0;
      changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        c[i] <= '0;
      end
    end else begin
      sync1   <= A;
      sync2   <= sync1;
      s       <= s_next;
      changed <= s_next ^ s;
      for (int i = 0; i < WIDTH; i++) begin
        c[i] <= c_next[i];
      end
    end
  end

  // Output polarity applied straight to the registered level.
  assign Y = (INVERT != 0) ? ~s : s;

endmodule

// File: tb/tb_multi_schmitt_not_gate.sv
// tb/tb_multi_schmitt_not_gate.sv - randomized and directed checks against a streak-based model
module tb_multi_schmitt_not_gate;

  localparam int W = 6;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] y_inv, chg_inv, y_buf, chg_buf;

  int n_cmp = 0;
  int n_err = 0;

  // Model: input delay line, accepted level and per-channel length of the current disagreement run.
  logic [W-1:0] m_d1 = '0, m_d2 = '0, m_s = '0, m_chg = '0;
  int           streak [W];

  always #5 clk = ~clk;

  multi_schmitt_not_gate #(.WIDTH(W), .FILTER(F), .INVERT(1)) dut_inv (
    .clk(clk), .rst(rst), .en(en), .A(a), .Y(y_inv), .changed(chg_inv));

  multi_schmitt_not_gate #(.WIDTH(W), .FILTER(F), .INVERT(0)) dut_buf (
    .clk(clk), .rst(rst), .en(en), .A(a), .Y(y_buf), .changed(chg_buf));

  task automatic model_edge();
    logic [W-1:0] ns;
    ns = m_s;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_s = '0; m_chg = '0;
      for (int i = 0; i < W; i++) streak[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!en) begin
          ns[i] = m_d2[i];
          streak[i] = 0;
        end else if (m_d2[i] == m_s[i]) begin
          streak[i] = 0;
        end else begin
          streak[i] = streak[i] + 1;
          if (streak[i] >= F) begin
            ns[i] = m_d2[i];
            streak[i] = 0;
          end
        end
      end
      m_chg = ns ^ m_s;
      m_s   = ns;
      m_d2  = m_d1;
      m_d1  = a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; a = '0;
    tick();
    rst = 1'b0;
    n_cmp++; if (y_inv !== 6'h3F) begin n_err++; $display("FAIL reset_y_inv got %h expected 3f", y_inv); end
    n_cmp++; if (chg_inv !== 6'h00) begin n_err++; $display("FAIL reset_chg got %h expected 00", chg_inv); end
    n_cmp++; if (y_buf !== 6'h00) begin n_err++; $display("FAIL reset_y_buf got %h expected 00", y_buf); end
  endtask

  task automatic test_step();
    a = 6'h01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) begin
        n_cmp++; if (y_inv !== 6'h3F) begin n_err++; $display("FAIL step_early got %h expected 3f", y_inv); end
      end
      if (e == 6) begin
        n_cmp++; if (y_inv !== 6'h3E) begin n_err++; $display("FAIL step_y got %h expected 3e", y_inv); end
        n_cmp++; if (chg_inv !== 6'h01) begin n_err++; $display("FAIL step_chg got %h expected 01", chg_inv); end
      end
      if (e == 7) begin
        n_cmp++; if (chg_inv !== 6'h00) begin n_err++; $display("FAIL step_chg_clear got %h expected 00", chg_inv); end
      end
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    a = 6'h02;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) a = 6'h00;
      tick();
      if (y_inv !== 6'h3F || chg_inv !== 6'h00) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL glitch_suppressed got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_bypass();
    en = 1'b0; a = 6'h2A;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 2) begin
        n_cmp++; if (y_inv !== 6'h3F) begin n_err++; $display("FAIL bypass_early got %h expected 3f", y_inv); end
      end
      if (e == 3) begin
        n_cmp++; if (y_inv !== 6'h15) begin n_err++; $display("FAIL bypass_y got %h expected 15", y_inv); end
        n_cmp++; if (chg_inv !== 6'h2A) begin n_err++; $display("FAIL bypass_chg got %h expected 2a", chg_inv); end
      end
      if (e == 4) begin
        n_cmp++; if (chg_inv !== 6'h00) begin n_err++; $display("FAIL bypass_chg_clear got %h expected 00", chg_inv); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    en = 1'b1; a = 6'h3F;
    for (int e = 0; e < 4; e++) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (y_inv !== 6'h3F) begin n_err++; $display("FAIL midrst_during got %h expected 3f", y_inv); end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        n_cmp++; if (y_inv !== 6'h3F) begin n_err++; $display("FAIL midrst_hold got %h expected 3f", y_inv); end
        n_cmp++; if (y_buf !== 6'h00) begin n_err++; $display("FAIL noninv_hold got %h expected 00", y_buf); end
      end
      if (e == 6) begin
        n_cmp++; if (y_inv !== 6'h00) begin n_err++; $display("FAIL midrst_accept got %h expected 00", y_inv); end
        n_cmp++; if (y_buf !== 6'h3F) begin n_err++; $display("FAIL noninv_accept got %h expected 3f", y_buf); end
        n_cmp++; if (chg_buf !== 6'h3F) begin n_err++; $display("FAIL noninv_chg got %h expected 3f", chg_buf); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) a = W'($urandom);
      if ($urandom_range(0, 24) == 0) en = ~en;
      rst = ($urandom_range(0, 149) == 0);
      tick();
      n_cmp++; if (y_inv !== ~m_s) begin n_err++; $display("FAIL rand_y_inv cyc %0d got %h expected %h", n, y_inv, ~m_s); end
      n_cmp++; if (y_buf !== m_s) begin n_err++; $display("FAIL rand_y_buf cyc %0d got %h expected %h", n, y_buf, m_s); end
      n_cmp++; if (chg_inv !== m_chg) begin n_err++; $display("FAIL rand_chg_inv cyc %0d got %h expected %h", n, chg_inv, m_chg); end
      n_cmp++; if (chg_buf !== m_chg) begin n_err++; $display("FAIL rand_chg_buf cyc %0d got %h expected %h", n, chg_buf, m_chg); end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) streak[i] = 0;
    #2;
    test_reset();
    test_step();
    test_reset();
    test_glitch();
    test_reset();
    test_bypass();
    test_reset();
    test_reset_mid_count();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
